axis_deadlock_monitor: RTL
==========================

# axis_deadlock_monitor

Simulation-side stall detector that consumes the per-kernel AXI-Stream block flags, sub-instance idle flags and sub-instance block flags collected by a kernel monitor top, and asserts `block` once the kernel has made no stream progress for a programmable number of cycles. It sits directly downstream of the kernel monitor top, one instance per HLS kernel: encoder, modulator, IFFT. Its `block` output drives the top's "find kernel block." report and the run's deadlock abort.

## Interface
- `NUM_AXIS`, default 4: number of AXI-Stream blocking flags.
- `NUM_INST`, default 3: number of monitored sub-instances.
- `THRESHOLD`, default 1024: consecutive stalled cycles before declaring a deadlock; legal range ≥ 2.
- `CNT_W`, default `$clog2(THRESHOLD+1)`: width of the stall counter.

Ports (clock and reset first):
- `clock` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `axis_block_sigs` in `NUM_AXIS`: bit i is 1 while stream i is blocked (inverted `*_blk_n`).
- `inst_idle_sigs` in `NUM_INST`: bit j is 1 while sub-instance j is idle.
- `inst_block_sigs` in `NUM_INST`: bit j is 1 while sub-instance j is blocked on a sub-kernel.
- `block` out 1: deadlock declared.
- `block_pulse` out 1: one-cycle strobe on the rising edge of `block`.
- `blk_axis_mask` out `NUM_AXIS`: snapshot of `axis_block_sigs` taken when the current stall episode started.
- `stall_cnt` out `CNT_W`: current stall counter value.

## Operation
Combinational stall term:
- `stall_raw = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs)`
- In words: some stream or sub-instance is blocked, and not everything is idle.

Stable stall:
- `stable = stall_raw & (axis_block_sigs == mask_q)`.
- `mask_q` drives `blk_axis_mask`.

State machine with states IDLE, WATCH, BLOCKED:
- IDLE:
  - If `stall_raw`: go to WATCH, `cnt<=1`, `mask_q<=axis_block_sigs`.
  - Otherwise `cnt` holds 0.
- WATCH:
  - If `stable` and `cnt==THRESHOLD-1`: go to BLOCKED, `cnt<=THRESHOLD`, `block<=1`, `block_pulse<=1`.
  - Else if `stable`: `cnt<=cnt+1`.
  - Else if `stall_raw` (mask changed, i.e. progress occurred): stay in WATCH, `cnt<=1`, `mask_q<=axis_block_sigs`.
  - Else: go to IDLE, `cnt<=0`.
- BLOCKED:
  - `cnt` saturates at `THRESHOLD`.
  - If not `stable`: go to IDLE, `block<=0`, `cnt<=0` (subject to Configuration).
- `block_pulse` is 1 only in the cycle following the WATCH→BLOCKED transition; at all other times it is 0.
- `inst_block_sigs` does not take part in the mask comparison. Only stream-flag changes count as progress.

## Timing
- Reset values: state=IDLE, `block=0`, `block_pulse=0`, `blk_axis_mask=0`, `stall_cnt=0`.
- Reset asserted mid-episode: all outputs clear asynchronously. After release, the counter restarts from IDLE.
- Latency: `block` rises right after the THRESHOLD-th consecutive rising edge at which the stall condition holds (the first sampled with `stall_raw`, the rest with `stable`). `block` is registered, not combinational.
- Exit: `block` falls one edge after `stable` drops. The same edge returns to IDLE, even if `stall_raw` is still 1 with a new mask; the next episode starts on the following edge.
- Simultaneous mask change and `cnt==THRESHOLD-1` in WATCH: the restart wins and `block` stays 0.
- `&inst_idle_sigs==1` forces `stall_raw=0` regardless of the block flags, so an all-idle kernel never reports.
- No handshake on the outputs. Consumers sample them on `clock`.

## Configuration
- `DEADLOCK_MON_STICKY_EN` defined: BLOCKED is terminal.
  - `block`, `blk_axis_mask` and `stall_cnt=THRESHOLD` hold until `reset`.
  - `block_pulse` still fires exactly once.
- Undefined: BLOCKED exits to IDLE as described in Operation.

## Test plan
All tests use `THRESHOLD=8`, `NUM_AXIS=4`, `NUM_INST=3`.

1. Reset, then hold `axis_block_sigs=4'b0010`, `inst_idle_sigs=3'b001`, `inst_block_sigs=0`. Expect `block=1` after the 8th edge, `block_pulse` high for exactly 1 cycle, `blk_axis_mask=4'b0010`, `stall_cnt=8` and holding.
2. Same stimulus, but change the mask to `4'b0100` after 6 edges. Expect `stall_cnt=1` on the change and `block` only 8 edges after the change, with `blk_axis_mask=4'b0100`.
3. Stall for 5 edges, then `axis_block_sigs=0` for 1 cycle, then stall again. Expect return to IDLE with `stall_cnt=0`, and a full 8 edges required afterwards.
4. `axis_block_sigs=4'b1111` with `inst_idle_sigs=3'b111`. Expect `block` to stay 0 and `stall_cnt` to stay 0 indefinitely.
5. After reaching BLOCKED, clear `axis_block_sigs`:
   - Without the macro: `block=0` one edge later.
   - With `DEADLOCK_MON_STICKY_EN`: `block` stays 1 until reset.
6. Assert `reset=0` while `stall_cnt=5`. Expect all outputs 0 immediately, without waiting for a clock edge; after release, `block` rises only after 8 further stalled edges.

Source files
------------

// File: rtl/axis_deadlock_monitor.sv
// axis_deadlock_monitor: stall detector for one HLS kernel.
// Declares a deadlock once the kernel has shown no AXI-Stream progress for
// THRESHOLD consecutive cycles while something is blocked and not all
// sub-instances are idle.
// Optional build macro: DEADLOCK_MON_STICKY_EN makes BLOCKED terminal until reset.
module axis_deadlock_monitor #(
    parameter int NUM_AXIS  = 4,
    parameter int NUM_INST  = 3,
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    output logic                block,
    output logic                block_pulse,
    output logic [NUM_AXIS-1:0] blk_axis_mask,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WATCH   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(THRESHOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESHOLD);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_AXIS-1:0] mask_q, mask_d;
    logic                block_q, block_d;
    logic                pulse_q, pulse_d;

    logic stall_raw;
    logic stable;

    // Stall terms: only stream-flag changes count as progress.
    always_comb begin
        stall_raw = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
        stable    = stall_raw & (axis_block_sigs == mask_q);
    end

    // Next-state and registered-output logic for the stall episode FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        block_d = block_q;
        pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                block_d = 1'b0;
                if (stall_raw) begin
                    state_d = WATCH;
                    cnt_d   = CNT_ONE;
                    mask_d  = axis_block_sigs;
                end else begin
                    cnt_d = '0;
                end
            end
            WATCH: begin
                if (stable && cnt_q == CNT_PRE) begin
                    state_d = BLOCKED;
                    cnt_d   = CNT_MAX;
                    block_d = 1'b1;
                    pulse_d = 1'b1;
                end else if (stable) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (stall_raw) begin
                    // Mask changed: progress happened, restart the episode.
                    cnt_d  = CNT_ONE;
                    mask_d = axis_block_sigs;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            BLOCKED: begin
                cnt_d = CNT_MAX;
`ifdef DEADLOCK_MON_STICKY_EN
                block_d = 1'b1;
`else
                if (!stable) begin
                    // Always pass through IDLE, even if a new stall is already present.
                    state_d = IDLE;
                    block_d = 1'b0;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                block_d = 1'b0;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            block_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            block_q <= block_d;
            pulse_q <= pulse_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        block         = block_q;
        block_pulse   = pulse_q;
        blk_axis_mask = mask_q;
        stall_cnt     = cnt_q;
    end

endmodule
